// File: rtl/note_sequence_follower.sv
// Score follower: walks the melody ROM and scores each entry as a hit (note held) or a miss (timeout).
// Define NOTE_SEQUENCE_FOLLOWER_TIMEOUT_EN to build the per-entry timeout and miss path.
module note_sequence_follower #(
  parameter int note_count     = 62,
  parameter int w_note         = 12,
  parameter int hold_cycles    = 2500000,
  parameter int timeout_cycles = 100000000,
  parameter int w_idx          = $clog2(note_count),
  parameter int w_cnt          = $clog2(note_count + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [w_note-1:0] det_note,
  input  logic [w_note-1:0] expected_note,
  output logic [w_idx-1:0]  cur_idx,
  output logic [2:0]        state,
  output logic              hit,
  output logic              miss,
  output logic [w_cnt-1:0]  hits,
  output logic [w_cnt-1:0]  misses,
  output logic              done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARM    = 3'd1,
    LISTEN = 3'd2,
    HOLD   = 3'd3,
    FIN    = 3'd4
  } state_t;

  localparam int w_hold = (hold_cycles > 1) ? $clog2(hold_cycles) : 1;

  state_t            st;
  logic [w_hold-1:0] hold_cnt;
  logic              match;
  logic              rest;
  logic              active;
  logic              tmo_expired;
  logic              take_hit;
  logic              take_miss;
  logic              last;

  assign match  = (det_note == expected_note);
  assign rest   = (expected_note == '0);
  assign active = (st == ARM) || (st == LISTEN) || (st == HOLD);
  assign last   = (cur_idx == w_idx'(note_count - 1));

  // A hit beats a timeout landing in the same cycle.
  assign take_hit  = active && !rest && (st == HOLD) && match &&
                     (hold_cnt == w_hold'(hold_cycles - 1));
  assign take_miss = active && !rest && !take_hit && tmo_expired;

`ifdef NOTE_SEQUENCE_FOLLOWER_TIMEOUT_EN
  localparam int w_tmo = (timeout_cycles > 1) ? $clog2(timeout_cycles) : 1;
  logic [w_tmo-1:0] tmo_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if (start || take_hit || take_miss) begin
      tmo_cnt <= '0;
    end else if (active) begin
      tmo_cnt <= tmo_cnt + w_tmo'(1);
    end
  end

  assign tmo_expired = active && (tmo_cnt == w_tmo'(timeout_cycles - 1));
`else
  assign tmo_expired = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st       <= IDLE;
      cur_idx  <= '0;
      hit      <= 1'b0;
      miss     <= 1'b0;
      hits     <= '0;
      misses   <= '0;
      done     <= 1'b0;
      hold_cnt <= '0;
    end else begin
      hit  <= 1'b0;
      miss <= 1'b0;
      if (start) begin
        st       <= ARM;
        cur_idx  <= '0;
        hits     <= '0;
        misses   <= '0;
        done     <= 1'b0;
        hold_cnt <= '0;
      end else if (active && rest) begin
        st   <= FIN;
        done <= 1'b1;
      end else if (take_hit || take_miss) begin
        hit      <= take_hit;
        miss     <= take_miss;
        hold_cnt <= '0;
        if (take_hit) hits   <= hits + w_cnt'(1);
        else          misses <= misses + w_cnt'(1);
        if (last) begin
          st   <= FIN;
          done <= 1'b1;
        end else begin
          st      <= ARM;
          cur_idx <= cur_idx + w_idx'(1);
        end
      end else begin
        case (st)
          // Release gate: a note still sounding from the last entry must drop first.
          ARM:    if (!match) st <= LISTEN;
          LISTEN: if (match) begin
                    st       <= HOLD;
                    hold_cnt <= '0;
                  end
          HOLD:   if (match) begin
                    hold_cnt <= hold_cnt + w_hold'(1);
                  end else begin
                    st       <= LISTEN;
                    hold_cnt <= '0;
                  end
          default: ;
        endcase
      end
    end
  end

  assign state = st;

endmodule

// File: tb/tb_note_sequence_follower.sv
// Bench for note_sequence_follower: directed table, hand sequences and a random run against a history-based model.
module tb_note_sequence_follower;

  localparam int N  = 4;
  localparam int H  = 4;
  localparam int TA = 20;
  localparam int TB = H + 2;
`ifdef NOTE_SEQUENCE_FOLLOWER_TIMEOUT_EN
  localparam bit TEN = 1'b1;
`else
  localparam bit TEN = 1'b0;
`endif

  localparam logic [11:0] NE = 12'h080;
  localparam logic [11:0] NG = 12'h010;
  localparam logic [11:0] NB = 12'h001;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [11:0] det_note = '0;

  logic [11:0] exp_a, exp_b;
  logic [1:0]  idx_a, idx_b;
  logic [2:0]  st_a, st_b;
  logic        hit_a, hit_b, miss_a, miss_b, done_a, done_b;
  logic [2:0]  hits_a, hits_b, misses_a, misses_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  function automatic logic [11:0] rom(input logic [1:0] i);
    case (i)
      2'd0:    rom = NE;
      2'd1:    rom = NG;
      2'd2:    rom = NG;
      default: rom = 12'h000;
    endcase
  endfunction

  assign exp_a = rom(idx_a);
  assign exp_b = rom(idx_b);

  note_sequence_follower #(.note_count(N), .w_note(12), .hold_cycles(H), .timeout_cycles(TA)) dut_a (
    .clk(clk), .rst(rst), .start(start), .det_note(det_note), .expected_note(exp_a),
    .cur_idx(idx_a), .state(st_a), .hit(hit_a), .miss(miss_a),
    .hits(hits_a), .misses(misses_a), .done(done_a));

  note_sequence_follower #(.note_count(N), .w_note(12), .hold_cycles(H), .timeout_cycles(TB)) dut_b (
    .clk(clk), .rst(rst), .start(start), .det_note(det_note), .expected_note(exp_b),
    .cur_idx(idx_b), .state(st_b), .hit(hit_b), .miss(miss_b),
    .hits(hits_b), .misses(misses_b), .done(done_b));

  // Packed view: {state, idx, hit, miss, hits, misses, done}
  function automatic logic [13:0] pk(input logic [2:0] s, input logic [1:0] i, input logic h,
                                     input logic m, input logic [2:0] hs, input logic [2:0] ms,
                                     input logic d);
    pk = {s, i, h, m, hs, ms, d};
  endfunction

  task automatic chk(input string name, input logic [13:0] act, input logic [13:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got {st,idx,hit,miss,hits,misses,done}=%b_%b_%b_%b_%b_%b_%b required %b_%b_%b_%b_%b_%b_%b",
               name, act[13:11], act[10:9], act[8], act[7], act[6:4], act[3:1], act[0],
               req[13:11], req[10:9], req[8], req[7], req[6:4], req[3:1], req[0]);
    end
  endtask

  task automatic step(input logic s, input logic [11:0] d);
    start    = s;
    det_note = d;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        start;
    logic [11:0] det;
    int          n;
    logic [2:0]  st;
    logic [1:0]  idx;
    logic        hit;
    logic        miss;
    logic [2:0]  hits;
    logic [2:0]  misses;
    logic        done;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t row(input logic s, input logic [11:0] d, input int n, input logic [2:0] st,
                               input logic [1:0] idx, input logic h, input logic m,
                               input logic [2:0] hs, input logic [2:0] ms, input logic dn);
    vec_t r;
    r.start = s; r.det = d; r.n = n; r.st = st; r.idx = idx; r.hit = h; r.miss = m;
    r.hits = hs; r.misses = ms; r.done = dn;
    return r;
  endfunction

  // Model: an entry is scored from its history -- cycles spent, whether the note was released,
  // and the length of the current run of matching cycles since release.
  bit       m_started, m_active, m_released, m_done, m_hit, m_miss;
  int       m_idx, m_hits, m_misses, m_age, m_run;

  task automatic model_step(input logic s, input logic [11:0] d);
    logic [11:0] e;
    bit          mt;
    m_hit  = 0;
    m_miss = 0;
    if (s) begin
      m_started = 1; m_active = 1; m_done = 0; m_idx = 0; m_hits = 0; m_misses = 0;
      m_age = 0; m_run = 0; m_released = 0;
    end else if (m_active) begin
      e = rom(2'(m_idx));
      if (e == 12'h000) begin
        m_active = 0; m_done = 1;
      end else begin
        mt = (d == e);
        m_age++;
        if (m_released && mt && m_run == H) m_hit = 1;
        else if (TEN && m_age == TA) m_miss = 1;
        else if (!m_released) m_released = !mt;
        else m_run = mt ? m_run + 1 : 0;
        if (m_hit || m_miss) begin
          if (m_hit) m_hits++; else m_misses++;
          if (m_idx == N - 1) begin
            m_active = 0; m_done = 1;
          end else begin
            m_idx++; m_age = 0; m_run = 0; m_released = 0;
          end
        end
      end
    end
  endtask

  function automatic logic [2:0] model_state();
    if (!m_started)     return 3'd0;
    if (m_done)         return 3'd4;
    if (!m_released)    return 3'd1;
    if (m_run == 0)     return 3'd2;
    return 3'd3;
  endfunction

  initial begin
    logic [11:0] rdet;
    logic        rstart;
    logic [2:0]  ha;
    logic [2:0]  ma;
    logic [11:0] pool [5];
    pool[0] = 12'h000; pool[1] = NE; pool[2] = NG; pool[3] = NE | NG; pool[4] = NB;

    // Reset state
    #12;
    chk("reset_a", pk(st_a, idx_a, hit_a, miss_a, hits_a, misses_a, done_a), 14'd0);
    chk("reset_b", pk(st_b, idx_b, hit_b, miss_b, hits_b, misses_b, done_b), 14'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Case 1: asynchronous reset while in HOLD
    step(1'b1, 12'h000);
    step(1'b0, 12'h000);
    step(1'b0, NE);
    step(1'b0, NE);
    chk("pre_reset_hold", pk(st_a, idx_a, hit_a, miss_a, hits_a, misses_a, done_a),
        pk(3'd3, 2'd0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0));
    #2 rst = 1'b1;
    #1;
    chk("async_reset", pk(st_a, idx_a, hit_a, miss_a, hits_a, misses_a, done_a), 14'd0);
    #1 rst = 1'b0;

    // Cases 2-5: directed table on the long-timeout instance
    tbl.push_back(row(1, 12'h000, 1, 3'd1, 2'd0, 0, 0, 3'd0, 3'd0, 0));
    tbl.push_back(row(0, 12'h000, 1, 3'd2, 2'd0, 0, 0, 3'd0, 3'd0, 0));
    tbl.push_back(row(0, NE,      1, 3'd3, 2'd0, 0, 0, 3'd0, 3'd0, 0));
    tbl.push_back(row(0, NE,      3, 3'd3, 2'd0, 0, 0, 3'd0, 3'd0, 0));
    tbl.push_back(row(0, NE,      1, 3'd1, 2'd1, 1, 0, 3'd1, 3'd0, 0));
    tbl.push_back(row(0, 12'h000, 1, 3'd2, 2'd1, 0, 0, 3'd1, 3'd0, 0));
    tbl.push_back(row(0, 12'h000, TA - 2, 3'd2, 2'd1, 0, 0, 3'd1, 3'd0, 0));
    if (TEN) begin
      tbl.push_back(row(0, 12'h000, 1, 3'd1, 2'd2, 0, 1, 3'd1, 3'd1, 0));
      ha = 3'd1; ma = 3'd1;
    end else begin
      tbl.push_back(row(0, 12'h000, 1, 3'd2, 2'd1, 0, 0, 3'd1, 3'd0, 0));
      tbl.push_back(row(0, NG,      1, 3'd3, 2'd1, 0, 0, 3'd1, 3'd0, 0));
      tbl.push_back(row(0, NG,      3, 3'd3, 2'd1, 0, 0, 3'd1, 3'd0, 0));
      tbl.push_back(row(0, NG,      1, 3'd1, 2'd2, 1, 0, 3'd2, 3'd0, 0));
      ha = 3'd2; ma = 3'd0;
    end
    tbl.push_back(row(0, NG,      10, 3'd1, 2'd2, 0, 0, ha, ma, 0));
    tbl.push_back(row(0, 12'h000, 1, 3'd2, 2'd2, 0, 0, ha, ma, 0));
    tbl.push_back(row(0, NG,      1, 3'd3, 2'd2, 0, 0, ha, ma, 0));
    tbl.push_back(row(0, NG,      3, 3'd3, 2'd2, 0, 0, ha, ma, 0));
    tbl.push_back(row(0, NG,      1, 3'd1, 2'd3, 1, 0, ha + 3'd1, ma, 0));
    tbl.push_back(row(0, NG,      1, 3'd4, 2'd3, 0, 0, ha + 3'd1, ma, 1));
    tbl.push_back(row(0, 12'h000, 5, 3'd4, 2'd3, 0, 0, ha + 3'd1, ma, 1));
    tbl.push_back(row(1, 12'h000, 1, 3'd1, 2'd0, 0, 0, 3'd0, 3'd0, 0));

    foreach (tbl[i]) begin
      for (int k = 0; k < tbl[i].n; k++) step(tbl[i].start, tbl[i].det);
      chk($sformatf("table_row%0d", i), pk(st_a, idx_a, hit_a, miss_a, hits_a, misses_a, done_a),
          pk(tbl[i].st, tbl[i].idx, tbl[i].hit, tbl[i].miss, tbl[i].hits, tbl[i].misses, tbl[i].done));
    end

    // Case 6: hold and timeout terminal counts coincide on the short-timeout instance
    step(1'b1, 12'h000);
    step(1'b0, 12'h000);
    step(1'b0, NE);
    for (int k = 0; k < 3; k++) step(1'b0, NE);
    chk("coincide_pre", pk(st_b, idx_b, hit_b, miss_b, hits_b, misses_b, done_b),
        pk(3'd3, 2'd0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0));
    step(1'b0, NE);
    chk("coincide_hit_wins", pk(st_b, idx_b, hit_b, miss_b, hits_b, misses_b, done_b),
        pk(3'd1, 2'd1, 1'b1, 1'b0, 3'd1, 3'd0, 1'b0));
    step(1'b1, 12'h000);
    step(1'b0, 12'h000);
    for (int k = 0; k < 3; k++) step(1'b0, NE | NG);
    chk("multi_bit_no_hold", pk(st_b, idx_b, hit_b, miss_b, hits_b, misses_b, done_b),
        pk(3'd2, 2'd0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0));

    // Random run against the model
    m_started = 0;
    rdet = 12'h000;
    for (int c = 0; c < 3000; c++) begin
      rstart = (c == 0) || ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 3) == 0) rdet = pool[$urandom_range(0, 4)];
      model_step(rstart, rdet);
      step(rstart, rdet);
      chk($sformatf("random_c%0d", c), pk(st_a, idx_a, hit_a, miss_a, hits_a, misses_a, done_a),
          pk(model_state(), 2'(m_idx), m_hit, m_miss, 3'(m_hits), 3'(m_misses), m_done));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
